// File: rtl/pattern_compare_pkg.sv
// Shared pattern-match definitions: default geometry
// and the search state encoding.
package pattern_compare_pkg;

  localparam int PM_ADDR_W    = 9;
  localparam int PM_DATA_W    = 8;
  localparam int PM_LAST_ADDR = 511;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } pm_state_t;

endpackage

// File: rtl/pattern_compare.sv
// Linear masked search over a synchronous-read memory,
// reporting the first matching address.
module pattern_compare
  import pattern_compare_pkg::*;
#(
  parameter int ADDR_W    = PM_ADDR_W,
  parameter int DATA_W    = PM_DATA_W,
  parameter int LAST_ADDR = PM_LAST_ADDR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc_flag,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] pattern_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              done_flag,
  output logic              match_found,
  output logic [ADDR_W-1:0] match_address
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(LAST_ADDR);

  pm_state_t         state;
  logic [DATA_W-1:0] pat_q;
  logic [DATA_W-1:0] mask_q;
  logic [ADDR_W-1:0] dly_addr;
  logic              dly_vld;
  logic              hit;

  assign hit = ((mem_data & mask_q) == pat_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pat_q         <= '0;
      mask_q        <= '0;
      mem_addr      <= '0;
      mem_rd        <= 1'b0;
      dly_addr      <= '0;
      dly_vld       <= 1'b0;
      done_flag     <= 1'b0;
      match_found   <= 1'b0;
      match_address <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          mem_addr <= '0;
          mem_rd   <= 1'b0;
          dly_vld  <= 1'b0;
          if (inc_flag) begin
            pat_q  <= pattern & pattern_mask;
            mask_q <= pattern_mask;
            mem_rd <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          // Abort outranks a compare landing on the same edge.
          if (!inc_flag) begin
            state    <= IDLE;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            dly_vld  <= 1'b0;
          end else if (dly_vld &&
                       (hit || dly_addr == LAST)) begin
            state         <= DONE;
            done_flag     <= 1'b1;
            match_found   <= hit;
            match_address <= hit ? dly_addr : LAST;
            mem_rd        <= 1'b0;
            dly_vld       <= 1'b0;
          end else begin
            dly_vld  <= mem_rd;
            dly_addr <= mem_addr;
            if (mem_rd) begin
              if (mem_addr == LAST) begin
                mem_rd <= 1'b0;
              end else begin
                mem_addr <= mem_addr + 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (!inc_flag) begin
            state       <= IDLE;
            done_flag   <= 1'b0;
            match_found <= 1'b0;
            mem_addr    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
